// File: rtl/pl_bus_tx_sched.sv
// pl_bus_tx_sched: round-robin scheduler that shares one PL-bus frame
// transmitter among NREQ requesters. It sequences each frame through
// start, wait-for-done (with timeout abort) and an enforced inter-frame gap.
module pl_bus_tx_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TO_CYC  = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       err,
    output logic                  tx_start,
    output logic [LEN_W-1:0]      tx_len,
    output logic [2:0]            tx_sel,
    output logic                  tx_abort,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  tx_ting,
    output logic                  tx_cmpt
);

    localparam int unsigned TO_W  = $clog2(TO_CYC + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t            state, state_n;
    logic [2:0]        ptr, ptr_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;

    logic [NREQ-1:0]   gnt_n, done_n, err_n;
    logic              tx_start_n, tx_abort_n, tx_ting_n, tx_cmpt_n;
    logic [LEN_W-1:0]  tx_len_n;
    logic [2:0]        tx_sel_n;

    logic              found;
    logic [2:0]        win;
    logic [NREQ-1:0]   win_oh;
    logic [LEN_W-1:0]  win_len;

    // Round-robin pick: first request at or after ptr, else first request from bit 0
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_oh  = '0;
        win_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                found     = 1'b1;
                win       = 3'(i);
                win_oh[i] = 1'b1;
                win_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                win       = 3'(i);
                win_oh[i] = 1'b1;
                win_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        to_cnt_n   = to_cnt;
        gap_cnt_n  = gap_cnt;
        gnt_n      = gnt;
        tx_len_n   = tx_len;
        tx_sel_n   = tx_sel;
        done_n     = '0;
        err_n      = '0;
        tx_start_n = 1'b0;
        tx_abort_n = 1'b0;
        tx_cmpt_n  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (found) begin
                    state_n  = S_START;
                    gnt_n    = win_oh;
                    tx_sel_n = win;
                    tx_len_n = win_len;
                    ptr_n    = (32'(win) == NREQ - 1) ? 3'd0 : win + 3'd1;
                end
            end
            S_START: begin
                // Zero-length frames complete without touching the transmitter
                // and skip the gap, since nothing went out on the bus.
                if (tx_len == '0) begin
                    done_n    = gnt;
                    tx_cmpt_n = 1'b1;
                    gnt_n     = '0;
                    tx_sel_n  = '0;
                    tx_len_n  = '0;
                    state_n   = S_IDLE;
                end else if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    to_cnt_n   = '0;
                    state_n    = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_done is tested first so it wins over a simultaneous timeout
                if (tx_done) begin
                    done_n    = gnt;
                    tx_cmpt_n = 1'b1;
                    gnt_n     = '0;
                    tx_sel_n  = '0;
                    tx_len_n  = '0;
                    gap_cnt_n = '0;
                    state_n   = S_GAP;
                end else if (to_cnt == TO_LAST) begin
                    err_n      = gnt;
                    tx_abort_n = 1'b1;
                    tx_cmpt_n  = 1'b1;
                    gnt_n      = '0;
                    tx_sel_n   = '0;
                    tx_len_n   = '0;
                    gap_cnt_n  = '0;
                    state_n    = S_GAP;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        tx_ting_n = (state_n != S_IDLE);
    end

    // State, counters and registered outputs; synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            tx_len   <= '0;
            tx_sel   <= '0;
            tx_abort <= 1'b0;
            tx_ting  <= 1'b0;
            tx_cmpt  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            to_cnt   <= to_cnt_n;
            gap_cnt  <= gap_cnt_n;
            gnt      <= gnt_n;
            done     <= done_n;
            err      <= err_n;
            tx_start <= tx_start_n;
            tx_len   <= tx_len_n;
            tx_sel   <= tx_sel_n;
            tx_abort <= tx_abort_n;
            tx_ting  <= tx_ting_n;
            tx_cmpt  <= tx_cmpt_n;
        end
    end

endmodule
